// File: rtl/fill_req_tracker.sv
// fill_req_tracker
// Miss-fill tracker placed directly upstream of the fill FIFO. Accepts
// line-miss requests, issues one AXI read-address request per miss tagged
// with the slot index, matches returning single-beat read data back to the
// stored line address by ID, and pushes {line_addr, data} into the fill FIFO.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   miss_valid_i/miss_addr_i        miss request in, miss_ready_o handshake
//   arid_o/araddr_o/arvalid_o       AXI read-address channel out
//   arready_i
//   rid_i/rdata_i/rvalid_i          AXI read-data channel in (single beat)
//   rready_o
//   fill_afull_i                    fill FIFO almost-full
//   fill_wren_o/fill_data_o         fill FIFO write port
//   outstanding_o                   busy slot count
//   err_o                           sticky unmatched-ID flag
module fill_req_tracker #(
  parameter int          ENTRIES = 8,
  parameter logic [15:0] ID_BASE = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         miss_valid_i,
  input  logic [63:0]  miss_addr_i,
  output logic         miss_ready_o,
  output logic [15:0]  arid_o,
  output logic [63:0]  araddr_o,
  output logic         arvalid_o,
  input  logic         arready_i,
  input  logic [15:0]  rid_i,
  input  logic [511:0] rdata_i,
  input  logic         rvalid_i,
  output logic         rready_o,
  input  logic         fill_afull_i,
  output logic         fill_wren_o,
  output logic [575:0] fill_data_o,
  output logic [4:0]   outstanding_o,
  output logic         err_o
);

  localparam int IW = $clog2(ENTRIES);

  logic [ENTRIES-1:0] r_busy;
  logic [57:0]        r_line [ENTRIES];
  logic               r_arvalid;
  logic [15:0]        r_arid;
  logic [63:0]        r_araddr;
  logic               r_wren;
  logic [575:0]       r_fill;
  logic [4:0]         r_cnt;
  logic               r_err;

  logic               w_any_free;
  logic [IW-1:0]      w_free_idx;
  logic               w_miss_fire;
  logic               w_r_fire;
  logic [IW-1:0]      w_r_slot;
  logic               w_r_match;
  logic               w_free_hit;

  // Lowest-index free slot: scan downward so the last hit wins.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_any_free = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  // A new miss can only be taken when the single AR register is empty or
  // draining this cycle.
  assign miss_ready_o = w_any_free && (!r_arvalid || arready_i);
  assign w_miss_fire  = miss_valid_i && miss_ready_o;

  assign rready_o = !fill_afull_i;
  assign w_r_fire = rvalid_i && !fill_afull_i;
  assign w_r_slot = rid_i[IW-1:0];

  // A slot whose request is still sitting in the AR register cannot have
  // legitimately returned data yet, so a beat claiming it is treated as stray.
  assign w_r_match = (rid_i[15:IW] == ID_BASE[15:IW]) && r_busy[w_r_slot] &&
                     !(r_arvalid && (r_arid[IW-1:0] == w_r_slot));
  assign w_free_hit = w_r_fire && w_r_match;

  // Line address store: no reset needed, validity is carried by r_busy.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_line
      always_ff @(posedge clk) begin
        if (w_miss_fire && (w_free_idx == IW'(gi)))
          r_line[gi] <= miss_addr_i[63:6];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_wren    <= 1'b0;
      r_fill    <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      // Allocation and free never touch the same slot in one cycle.
      if (w_miss_fire) r_busy[w_free_idx] <= 1'b1;
      if (w_free_hit)  r_busy[w_r_slot]   <= 1'b0;

      if (w_miss_fire) begin
        r_arvalid <= 1'b1;
        r_arid    <= ID_BASE | 16'(w_free_idx);
        r_araddr  <= {miss_addr_i[63:6], 6'b0};
      end else if (arready_i) begin
        r_arvalid <= 1'b0;
      end

      r_wren <= w_free_hit;
      if (w_free_hit) r_fill <= {r_line[w_r_slot], 6'b0, rdata_i};

      r_cnt <= r_cnt + 5'(w_miss_fire) - 5'(w_free_hit);

      if (w_r_fire && !w_r_match) r_err <= 1'b1;
    end
  end

  assign arvalid_o     = r_arvalid;
  assign arid_o        = r_arid;
  assign araddr_o      = r_araddr;
  assign fill_wren_o   = r_wren;
  assign fill_data_o   = r_fill;
  assign outstanding_o = r_cnt;
  assign err_o         = r_err;

endmodule

// File: tb/tb_fill_req_tracker.sv
// Self-checking bench for fill_req_tracker (ENTRIES=8, ID_BASE=0).
module tb_fill_req_tracker;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss_valid_i = 1'b0;
  logic [63:0]  miss_addr_i = '0;
  logic         miss_ready_o;
  logic [15:0]  arid_o;
  logic [63:0]  araddr_o;
  logic         arvalid_o;
  logic         arready_i = 1'b0;
  logic [15:0]  rid_i = '0;
  logic [511:0] rdata_i = '0;
  logic         rvalid_i = 1'b0;
  logic         rready_o;
  logic         fill_afull_i = 1'b0;
  logic         fill_wren_o;
  logic [575:0] fill_data_o;
  logic [4:0]   outstanding_o;
  logic         err_o;

  fill_req_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid_i(miss_valid_i), .miss_addr_i(miss_addr_i), .miss_ready_o(miss_ready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .fill_afull_i(fill_afull_i), .fill_wren_o(fill_wren_o), .fill_data_o(fill_data_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the set of outstanding misses as an 8-entry table of
  // line addresses, plus the one pending AR request and the last fill.
  bit           m_busy [8];
  logic [63:0]  m_line [8];
  bit           m_arv;
  int           m_arslot;
  logic [63:0]  m_araddr;
  bit           m_wren;
  logic [575:0] m_fill;
  bit           m_err;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin m_busy[i] = 0; m_line[i] = '0; end
    m_arv = 0; m_arslot = 0; m_araddr = '0; m_wren = 0; m_fill = '0; m_err = 0;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m_busy[i];
    return n;
  endfunction

  // One clock: drive inputs at negedge, check combinational outputs, advance
  // model across the edge, check registered outputs after the edge.
  task automatic step(input bit mv, input logic [63:0] ma, input bit ar,
                      input bit rv, input logic [15:0] rid, input logic [511:0] rd,
                      input bit af);
    int  free_idx;
    bit  exp_mr, rfire, match;
    int  slot;
    @(negedge clk);
    miss_valid_i = mv; miss_addr_i = ma; arready_i = ar;
    rvalid_i = rv; rid_i = rid; rdata_i = rd; fill_afull_i = af;
    #1;
    free_idx = -1;
    for (int i = 7; i >= 0; i--) if (!m_busy[i]) free_idx = i;
    exp_mr = (free_idx >= 0) && (!m_arv || ar);
    chk("miss_ready", {575'd0, miss_ready_o}, {575'd0, exp_mr});
    chk("rready", {575'd0, rready_o}, {575'd0, !af});

    rfire = rv && !af;
    slot  = int'(rid[2:0]);
    match = (rid[15:3] == 13'd0) && m_busy[slot] && !(m_arv && m_arslot == slot);
    m_wren = rfire && match;
    if (m_wren) begin
      m_fill = {m_line[slot], rd};
      m_busy[slot] = 0;
    end
    if (rfire && !match) m_err = 1;
    if (mv && exp_mr) begin
      m_busy[free_idx] = 1;
      m_line[free_idx] = {ma[63:6], 6'b0};
      m_arv = 1; m_arslot = free_idx; m_araddr = {ma[63:6], 6'b0};
    end else if (ar) begin
      m_arv = 0;
    end

    @(posedge clk); #1;
    chk("arvalid", {575'd0, arvalid_o}, {575'd0, m_arv});
    if (m_arv) begin
      chk("arid", {560'd0, arid_o}, 576'(m_arslot));
      chk("araddr", {512'd0, araddr_o}, {512'd0, m_araddr});
    end
    chk("fill_wren", {575'd0, fill_wren_o}, {575'd0, m_wren});
    chk("fill_data", fill_data_o, m_fill);
    chk("outstanding", {571'd0, outstanding_o}, 576'(model_count()));
    chk("err", {575'd0, err_o}, {575'd0, m_err});
  endtask

  task automatic idle(input bit ar);
    step(0, '0, ar, 0, '0, '0, 0);
  endtask

  // Asserts reset between edges and checks that state clears without a clock.
  task automatic do_reset();
    @(negedge clk);
    miss_valid_i = 0; arready_i = 0; rvalid_i = 0; fill_afull_i = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_arvalid", {575'd0, arvalid_o}, 576'd0);
    chk("rst_arid", {560'd0, arid_o}, 576'd0);
    chk("rst_araddr", {512'd0, araddr_o}, 576'd0);
    chk("rst_wren", {575'd0, fill_wren_o}, 576'd0);
    chk("rst_fill_data", fill_data_o, 576'd0);
    chk("rst_outstanding", {571'd0, outstanding_o}, 576'd0);
    chk("rst_err", {575'd0, err_o}, 576'd0);
    chk("rst_miss_ready", {575'd0, miss_ready_o}, 576'd1);
    chk("rst_rready", {575'd0, rready_o}, 576'd1);
    model_clear();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    bit           mv;
    logic [63:0]  addr;
    bit           ar;
    bit           rv;
    logic [15:0]  rid;
    bit           af;
    bit           e_arv;
    logic [15:0]  e_arid;
    logic [63:0]  e_araddr;
    bit           e_wren;
    logic [63:0]  e_faddr;
    logic [4:0]   e_out;
    bit           e_err;
  } vec_t;

  vec_t vecs [6];
  logic [511:0] a5;

  initial begin
    a5 = {64{8'hA5}};
    model_clear();
    do_reset();

    // Single miss, its fill, then a stray beat to a free slot.
    vecs[0] = '{1, 64'h0000_1234_5678_9A7F, 0, 0, 16'd0, 0, 1, 16'd0, 64'h0000_1234_5678_9A40, 0, 64'd0, 5'd1, 0};
    vecs[1] = '{0, 64'd0, 1, 0, 16'd0, 0, 0, 16'd0, 64'h0000_1234_5678_9A40, 0, 64'd0, 5'd1, 0};
    vecs[2] = '{0, 64'd0, 0, 1, 16'd0, 0, 0, 16'd0, 64'h0000_1234_5678_9A40, 1, 64'h0000_1234_5678_9A40, 5'd0, 0};
    vecs[3] = '{0, 64'd0, 0, 0, 16'd0, 0, 0, 16'd0, 64'h0000_1234_5678_9A40, 0, 64'h0000_1234_5678_9A40, 5'd0, 0};
    vecs[4] = '{0, 64'd0, 0, 1, 16'd5, 0, 0, 16'd0, 64'h0000_1234_5678_9A40, 0, 64'h0000_1234_5678_9A40, 5'd0, 1};
    vecs[5] = '{0, 64'd0, 0, 0, 16'd0, 0, 0, 16'd0, 64'h0000_1234_5678_9A40, 0, 64'h0000_1234_5678_9A40, 5'd0, 1};
    for (int v = 0; v < 6; v++) begin
      step(vecs[v].mv, vecs[v].addr, vecs[v].ar, vecs[v].rv, vecs[v].rid, a5, vecs[v].af);
      chk($sformatf("vec%0d_arvalid", v), {575'd0, arvalid_o}, {575'd0, vecs[v].e_arv});
      chk($sformatf("vec%0d_arid", v), {560'd0, arid_o}, {560'd0, vecs[v].e_arid});
      chk($sformatf("vec%0d_araddr", v), {512'd0, araddr_o}, {512'd0, vecs[v].e_araddr});
      chk($sformatf("vec%0d_wren", v), {575'd0, fill_wren_o}, {575'd0, vecs[v].e_wren});
      chk($sformatf("vec%0d_faddr", v), {512'd0, fill_data_o[575:512]}, {512'd0, vecs[v].e_faddr});
      if (vecs[v].e_wren) chk($sformatf("vec%0d_fdata", v), {64'd0, fill_data_o[511:0]}, {64'd0, a5});
      chk($sformatf("vec%0d_out", v), {571'd0, outstanding_o}, {571'd0, vecs[v].e_out});
      chk($sformatf("vec%0d_err", v), {575'd0, err_o}, {575'd0, vecs[v].e_err});
    end
    do_reset();

    // Fill all eight slots back to back.
    for (int i = 0; i < 8; i++) step(1, 64'(i) << 6, 1, 0, '0, '0, 0);
    chk("full_ready", {575'd0, miss_ready_o}, 576'd0);
    chk("full_last_id", {560'd0, arid_o}, 576'd7);
    chk("full_out", {571'd0, outstanding_o}, 576'd8);
    step(1, 64'h5000, 1, 0, '0, '0, 0);
    step(0, '0, 0, 1, 16'd3, {16{32'h3333_3333}}, 0);
    chk("free3_ready", {575'd0, miss_ready_o}, 576'd1);
    step(1, 64'h3000, 0, 0, '0, '0, 0);
    chk("reuse_id3", {560'd0, arid_o}, 576'd3);
    idle(1);

    // Out-of-order return, one fill per cycle.
    step(0, '0, 0, 1, 16'd7, {16{32'h7777_0000}}, 0);
    chk("ooo7_addr", {512'd0, fill_data_o[575:512]}, 576'h1C0);
    step(0, '0, 0, 1, 16'd0, {16{32'h0000_0000}}, 0);
    chk("ooo0_addr", {512'd0, fill_data_o[575:512]}, 576'h0);
    chk("ooo0_wren", {575'd0, fill_wren_o}, 576'd1);
    step(0, '0, 0, 1, 16'd4, {16{32'h4444_0000}}, 0);
    chk("ooo4_addr", {512'd0, fill_data_o[575:512]}, 576'h100);

    // Almost-full back-pressure with a beat waiting.
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 0, 1, 16'd1, {16{32'h1111_1111}}, 1);
      chk("afull_rready", {575'd0, rready_o}, 576'd0);
      chk("afull_wren", {575'd0, fill_wren_o}, 576'd0);
    end
    step(0, '0, 0, 1, 16'd1, {16{32'h1111_1111}}, 0);
    chk("afull_release_wren", {575'd0, fill_wren_o}, 576'd1);
    chk("afull_release_addr", {512'd0, fill_data_o[575:512]}, 576'h40);
    do_reset();

    // AR stall with a new miss waiting, then reset mid-wait.
    step(1, 64'hABC0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 64'h2_0000 + 64'(i), 0, 0, '0, '0, 0);
      chk("stall_arvalid", {575'd0, arvalid_o}, 576'd1);
      chk("stall_arid", {560'd0, arid_o}, 576'd0);
      chk("stall_araddr", {512'd0, araddr_o}, 576'hABC0);
      chk("stall_ready", {575'd0, miss_ready_o}, 576'd0);
    end
    do_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      logic [15:0] rid;
      rid = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) rid = rid | 16'h0100;
      step($urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 1) == 1, rid, {16{$urandom}}, $urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
